// File: rtl/program_load_arbiter.sv
// Instruction memory owner: arbitrates CPU fetch against the UART program loader.
// First UART word enters LOAD mode; END_WORD (or an idle timeout) returns to RUN.
module program_load_arbiter #(
    parameter int                    ADDRESS_WIDTH  = 11,
    parameter int                    DATA_WIDTH     = 16,
    parameter logic [DATA_WIDTH-1:0] END_WORD       = '0,
    parameter int                    TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic                     uart_valid_in,
    input  logic [DATA_WIDTH-1:0]    uart_data_in,
    output logic                     uart_ready_out,
    input  logic                     cpu_req_in,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr_in,
    output logic                     cpu_gnt_out,
    output logic                     cpu_rvalid_out,
    output logic [DATA_WIDTH-1:0]    cpu_rdata_out,
    output logic                     cpu_hold_out,
    output logic                     mem_we_out,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_out,
    output logic [DATA_WIDTH-1:0]    mem_wdata_out,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_in,
    output logic                     load_done_out,
    output logic [ADDRESS_WIDTH:0]   load_count_out,
    output logic                     overrun_err_out,
    output logic                     overflow_err_out,
    output logic                     timeout_err_out
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int CW = ADDRESS_WIDTH + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_RUN,
        S_IDLE,
        S_WRITE
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovr_q, ovr_d;
    logic                  ovf_q, ovf_d;
    logic                  to_q, to_d;
    logic                  done_q, done_d;
    logic                  rvalid_q;
    logic                  capture;

    assign capture = uart_valid_in && (state_q != S_WRITE);

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        hold_d        = hold_q;
        timer_d       = timer_q;
        count_d       = count_q;
        ovr_d         = ovr_q;
        ovf_d         = ovf_q;
        to_d          = to_q;
        done_d        = 1'b0;
        cpu_gnt_out   = 1'b0;
        mem_we_out    = 1'b0;
        mem_addr_out  = wr_ptr_q;
        mem_wdata_out = hold_q;
        unique case (state_q)
            S_RUN: begin
                cpu_gnt_out  = cpu_req_in && !uart_valid_in;
                mem_addr_out = cpu_addr_in;
                if (capture) begin
                    state_d = S_WRITE;
                    hold_d  = uart_data_in;
                    timer_d = '0;
                    count_d = '0;
                    ovr_d   = 1'b0;
                    ovf_d   = 1'b0;
                    to_d    = 1'b0;
                end
            end
            S_IDLE: begin
                // A word arriving on the timeout cycle still counts.
                if (capture) begin
                    state_d = S_WRITE;
                    hold_d  = uart_data_in;
                    timer_d = '0;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = S_RUN;
                    wr_ptr_d = '0;
                    to_d     = 1'b1;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WRITE: begin
                mem_we_out = 1'b1;
                if (uart_valid_in) begin
                    ovr_d = 1'b1;
                end
                if (count_q != '1) begin
                    count_d = count_q + CW'(1);
                end
                if (hold_q == END_WORD) begin
                    state_d  = S_RUN;
                    wr_ptr_d = '0;
                    done_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    if (wr_ptr_q == '1) begin
                        wr_ptr_d = '0;
                        ovf_d    = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q  <= S_RUN;
            wr_ptr_q <= '0;
            hold_q   <= '0;
            timer_q  <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            ovf_q    <= 1'b0;
            to_q     <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            hold_q   <= hold_d;
            timer_q  <= timer_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            ovf_q    <= ovf_d;
            to_q     <= to_d;
            done_q   <= done_d;
            rvalid_q <= cpu_gnt_out;
        end
    end

    assign uart_ready_out   = (state_q != S_WRITE);
    assign cpu_hold_out     = (state_q != S_RUN);
    assign cpu_rvalid_out   = rvalid_q;
    assign cpu_rdata_out    = mem_rdata_in;
    assign load_done_out    = done_q;
    assign load_count_out   = count_q;
    assign overrun_err_out  = ovr_q;
    assign overflow_err_out = ovf_q;
    assign timeout_err_out  = to_q;

endmodule
